// File: rtl/hc_fwd.sv
// ---------------------------------------------------------------------------
// hc_fwd -- hazard controller with operand forwarding for a five-stage core
//
// Drives the stall/flush controls of the F/D/E/M/W stages. Also drives
// registered E-stage operand-forwarding selects. It detects load-use hazards
// and RAW/WAW hazards against results still owed by the multi-cycle unit
// (MDU). Those results are tracked by a one-bit-per-register scoreboard.
// A saturating counter records the number of cycles in which D was stalled.
//
// Parameters
//   REG_W   register-address width (scoreboard holds 2**REG_W bits)
//   FWD_EN  1: forwarding enabled; 0: stall-only, forwarding selects stay 00
//   CNT_W   stall-counter width
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   je                         branch/jump taken, resolved in E
//   busy_M                     LSU busy, freezes F..M and bubbles W
//   rs1_addr/rs2_addr          D-stage source registers
//   rs1_used/rs2_used          D instruction actually reads that source
//   rd_D                       D-stage destination (WAW check)
//   rd_E/we_E, rd_M/we_M       pipeline destinations and their write enables
//   load_E                     E instruction is a load
//   long_E, mdu_ready          E instruction launches on the MDU / MDU can accept
//   long_done, long_rd         MDU writes long_rd into the regfile this cycle
//   stall_*/flush_*            per-stage controls (combinational)
//   fwd_rs1_E/fwd_rs2_E        E operand select: 00 regfile, 01 M, 10 W
//   stall_cnt                  saturating count of stall_D cycles
// ---------------------------------------------------------------------------
module hc_fwd #(
    parameter int REG_W  = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             je,
    input  logic             busy_M,
    input  logic [REG_W-1:0] rs1_addr,
    input  logic [REG_W-1:0] rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] rd_D,
    input  logic [REG_W-1:0] rd_E,
    input  logic [REG_W-1:0] rd_M,
    input  logic             we_E,
    input  logic             we_M,
    input  logic             load_E,
    input  logic             long_E,
    input  logic             mdu_ready,
    input  logic             long_done,
    input  logic [REG_W-1:0] long_rd,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             stall_E,
    output logic             flush_E,
    output logic             stall_M,
    output logic             flush_M,
    output logic             stall_W,
    output logic             flush_W,
    output logic [1:0]       fwd_rs1_E,
    output logic [1:0]       fwd_rs2_E,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int               NREG    = 1 << REG_W;
    localparam logic [REG_W-1:0] X0      = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    logic [NREG-1:0]  r_sb;
    logic [1:0]       r_fwd1;
    logic [1:0]       r_fwd2;
    logic [CNT_W-1:0] r_cnt;

    logic [NREG-1:0]  w_clr;
    logic [NREG-1:0]  w_sb_eff;
    logic [NREG-1:0]  w_sb_next;
    logic             w_rs1_e, w_rs2_e, w_rs1_m, w_rs2_m;
    logic             w_load_use, w_raw, w_waw, w_hazard, w_launch;
    logic [1:0]       w_fwd1, w_fwd2;

    // A completing MDU write is visible through the write-through regfile in
    // the same cycle, so its bit is masked off before any hazard check.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        w_clr          = '0;
        w_clr[long_rd] = long_done;
        w_sb_eff       = r_sb & ~w_clr;
    end

    // Source/destination matches. x0 never matches; unused sources and
    // non-writing destinations are ignored.
    assign w_rs1_e = rs1_used && (rs1_addr != X0) && we_E && (rs1_addr == rd_E);
    assign w_rs2_e = rs2_used && (rs2_addr != X0) && we_E && (rs2_addr == rd_E);
    assign w_rs1_m = rs1_used && (rs1_addr != X0) && we_M && (rs1_addr == rd_M);
    assign w_rs2_m = rs2_used && (rs2_addr != X0) && we_M && (rs2_addr == rd_M);

    assign w_load_use = load_E && (w_rs1_e || w_rs2_e);
    assign w_raw      = (rs1_used && w_sb_eff[rs1_addr]) || (rs2_used && w_sb_eff[rs2_addr]);
    assign w_waw      = (rd_D != X0) && w_sb_eff[rd_D];

    // Without forwarding, any in-flight producer of a D source must drain first.
    assign w_hazard = w_load_use || w_raw || w_waw ||
                      ((FWD_EN == 0) && (w_rs1_e || w_rs2_e || w_rs1_m || w_rs2_m));

    // Prioritised stage controls; the LSU freeze dominates everything.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        stall_E = 1'b0;
        flush_E = 1'b0;
        stall_M = 1'b0;
        flush_M = 1'b0;
        stall_W = 1'b0;
        flush_W = 1'b0;
        if (busy_M) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else if (long_E && !mdu_ready) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
        end else if (je) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (w_hazard) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    // Forwarding selects for the D instruction, applied when it reaches E.
    // A load match in E stalls, so a load producer only ever forwards from W.
    always_comb begin
        w_fwd1 = FWD_RF;
        w_fwd2 = FWD_RF;
        if (FWD_EN != 0) begin
            if (w_rs1_e && !load_E) begin
                w_fwd1 = FWD_M;
            end else if (w_rs1_m) begin
                w_fwd1 = FWD_W;
            end
            if (w_rs2_e && !load_E) begin
                w_fwd2 = FWD_M;
            end else if (w_rs2_m) begin
                w_fwd2 = FWD_W;
            end
        end
    end

    // A launch that is held in E must not mark its destination yet.
    assign w_launch = long_E && mdu_ready && !stall_E && (rd_E != X0);

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        w_sb_next = w_sb_eff;
        if (w_launch) begin
            w_sb_next[rd_E] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            // NOTE: the scoreboard is plain flops and must be reset, or stale bits would stall D forever.
            r_sb   <= '0;
            r_fwd1 <= FWD_RF;
            r_fwd2 <= FWD_RF;
            r_cnt  <= '0;
        end else begin
            r_sb <= w_sb_next;
            if (!stall_E) begin
                r_fwd1 <= flush_E ? FWD_RF : w_fwd1;
                r_fwd2 <= flush_E ? FWD_RF : w_fwd2;
            end
            if (stall_D && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign fwd_rs1_E = r_fwd1;
    assign fwd_rs2_E = r_fwd2;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hc_fwd.sv
// ---------------------------------------------------------------------------
// tb_hc_fwd -- scoreboard bench for hc_fwd
//
// Two instances share one set of inputs. dut1 is built with forwarding and a
// 32-bit counter. dut0 is built stall-only with a 3-bit counter, so its
// counter reaches saturation. Each driven cycle pushes the expected outputs,
// computed by a reference model, into a queue. A monitor pops and compares
// them on the falling edge.
// ---------------------------------------------------------------------------
module tb_hc_fwd;

    typedef struct packed {
        logic       rst;
        logic       je;
        logic       busy;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd_D;
        logic [4:0] rd_E;
        logic [4:0] rd_M;
        logic       we_E;
        logic       we_M;
        logic       load_E;
        logic       long_E;
        logic       mdu_ready;
        logic       long_done;
        logic [4:0] long_rd;
    } stim_t;

    typedef struct {
        logic [8:0]  ctl1;
        logic [8:0]  ctl0;
        logic [3:0]  fwd1;
        logic [31:0] cnt1;
        logic [2:0]  cnt0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, je, busy_M, rs1_used, rs2_used;
    logic [4:0] rs1_addr, rs2_addr, rd_D, rd_E, rd_M, long_rd;
    logic       we_E, we_M, load_E, long_E, mdu_ready, long_done;

    logic        sF1, sD1, fD1, sE1, fE1, sM1, fM1, sW1, fW1;
    logic        sF0, sD0, fD0, sE0, fE0, sM0, fM0, sW0, fW0;
    logic [1:0]  f1a, f1b, f0a, f0b;
    logic [31:0] cnt1;
    logic [2:0]  cnt0;

    hc_fwd #(.REG_W(5), .FWD_EN(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .je(je), .busy_M(busy_M),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_D(rd_D), .rd_E(rd_E), .rd_M(rd_M), .we_E(we_E), .we_M(we_M),
        .load_E(load_E), .long_E(long_E), .mdu_ready(mdu_ready),
        .long_done(long_done), .long_rd(long_rd),
        .stall_F(sF1), .stall_D(sD1), .flush_D(fD1), .stall_E(sE1), .flush_E(fE1),
        .stall_M(sM1), .flush_M(fM1), .stall_W(sW1), .flush_W(fW1),
        .fwd_rs1_E(f1a), .fwd_rs2_E(f1b), .stall_cnt(cnt1)
    );

    hc_fwd #(.REG_W(5), .FWD_EN(0), .CNT_W(3)) dut0 (
        .clk(clk), .reset(reset), .je(je), .busy_M(busy_M),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_D(rd_D), .rd_E(rd_E), .rd_M(rd_M), .we_E(we_E), .we_M(we_M),
        .load_E(load_E), .long_E(long_E), .mdu_ready(mdu_ready),
        .long_done(long_done), .long_rd(long_rd),
        .stall_F(sF0), .stall_D(sD0), .flush_D(fD0), .stall_E(sE0), .flush_E(fE0),
        .stall_M(sM0), .flush_M(fM0), .stall_W(sW0), .flush_W(fW0),
        .fwd_rs1_E(f0a), .fwd_rs2_E(f0b), .stall_cnt(cnt0)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model state: set of registers owed by the MDU, the selects
    // the E stage currently holds, and the stall counts.
    bit          pend[32];
    logic [1:0]  m_fwd1, m_fwd2;
    int unsigned m_cnt1;
    int          m_cnt0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_hit(logic [4:0] a, logic used, logic [4:0] rd, logic we);
        return used && (a != 5'd0) && we && (a == rd);
    endfunction

    // Register still owed: pending and not being written back this very cycle.
    function automatic bit owed(logic [4:0] r, stim_t s);
        return pend[r] && !(s.long_done && (s.long_rd == r));
    endfunction

    // Order: stall_F stall_D flush_D stall_E flush_E stall_M flush_M stall_W flush_W
    function automatic logic [8:0] controls(stim_t s, bit haz);
        if (s.busy)                      return 9'b110101001;
        else if (s.long_E && !s.mdu_ready) return 9'b110100100;
        else if (s.je)                   return 9'b001010000;
        else if (haz)                    return 9'b110010000;
        else                             return 9'b000000000;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t       e;
        bit         e1, e2, m1, m2, hz1, hz0;
        logic [8:0] c1, c0;
        logic [1:0] n1, n2;
        @(posedge clk);
        #1;
        reset = s.rst; je = s.je; busy_M = s.busy;
        rs1_addr = s.rs1; rs2_addr = s.rs2; rs1_used = s.u1; rs2_used = s.u2;
        rd_D = s.rd_D; rd_E = s.rd_E; rd_M = s.rd_M; we_E = s.we_E; we_M = s.we_M;
        load_E = s.load_E; long_E = s.long_E; mdu_ready = s.mdu_ready;
        long_done = s.long_done; long_rd = s.long_rd;

        e1 = src_hit(s.rs1, s.u1, s.rd_E, s.we_E);
        e2 = src_hit(s.rs2, s.u2, s.rd_E, s.we_E);
        m1 = src_hit(s.rs1, s.u1, s.rd_M, s.we_M);
        m2 = src_hit(s.rs2, s.u2, s.rd_M, s.we_M);
        hz1 = (s.load_E && (e1 || e2)) ||
              (s.u1 && owed(s.rs1, s)) || (s.u2 && owed(s.rs2, s)) ||
              ((s.rd_D != 5'd0) && owed(s.rd_D, s));
        hz0 = hz1 || e1 || e2 || m1 || m2;
        c1  = controls(s, hz1);
        c0  = controls(s, hz0);

        e.ctl1 = c1;
        e.ctl0 = c0;
        e.fwd1 = {m_fwd1, m_fwd2};
        e.cnt1 = m_cnt1;
        e.cnt0 = 3'(m_cnt0);
        exp_q.push_back(e);

        // Advance the model to the state after this cycle's edge.
        n1 = (e1 && !s.load_E) ? 2'b01 : (m1 ? 2'b10 : 2'b00);
        n2 = (e2 && !s.load_E) ? 2'b01 : (m2 ? 2'b10 : 2'b00);
        if (s.rst) begin
            foreach (pend[i]) pend[i] = 1'b0;
            m_fwd1 = 2'b00;
            m_fwd2 = 2'b00;
            m_cnt1 = 0;
            m_cnt0 = 0;
        end else begin
            if (!c1[5]) begin
                m_fwd1 = c1[4] ? 2'b00 : n1;
                m_fwd2 = c1[4] ? 2'b00 : n2;
            end
            if (c1[7] && (m_cnt1 != 32'hFFFF_FFFF)) m_cnt1++;
            if (c0[7] && (m_cnt0 < 7)) m_cnt0++;
            if (s.long_done) pend[s.long_rd] = 1'b0;
            if (s.long_E && s.mdu_ready && !c1[5] && (s.rd_E != 5'd0)) pend[s.rd_E] = 1'b1;
        end
    endtask

    // Monitor: outputs are valid every cycle; compare away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ctl_fwd", 32'({sF1, sD1, fD1, sE1, fE1, sM1, fM1, sW1, fW1}), 32'(e.ctl1));
                check("ctl_nofwd", 32'({sF0, sD0, fD0, sE0, fE0, sM0, fM0, sW0, fW0}), 32'(e.ctl0));
                check("fwd_sel", 32'({f1a, f1b}), 32'(e.fwd1));
                check("fwd_sel_nofwd", 32'({f0a, f0b}), 32'd0);
                check("stall_cnt", cnt1, e.cnt1);
                check("stall_cnt_sat", 32'(cnt0), 32'(e.cnt0));
            end
        end
    end

    initial begin
        stim_t s;
        int    budget;
        foreach (pend[i]) pend[i] = 1'b0;
        m_fwd1 = 2'b00; m_fwd2 = 2'b00; m_cnt1 = 0; m_cnt0 = 0;
        reset = 1'b1; je = 1'b0; busy_M = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd_D = '0; rd_E = '0; rd_M = '0; we_E = 1'b0; we_M = 1'b0;
        load_E = 1'b0; long_E = 1'b0; mdu_ready = 1'b0; long_done = 1'b0; long_rd = '0;
        repeat (2) @(posedge clk);

        // Reset state
        apply(idle());

        // ALU chain: producer in E, then in M
        s = idle(); s.we_E = 1; s.rd_E = 5; s.rs1 = 5; s.u1 = 1; apply(s);
        s = idle(); s.we_M = 1; s.rd_M = 5; s.rs1 = 5; s.u1 = 1; apply(s);
        apply(idle());

        // Load-use: one bubble, then the load forwards from W
        s = idle(); s.we_E = 1; s.load_E = 1; s.rd_E = 7; s.rs2 = 7; s.u2 = 1; apply(s);
        s = idle(); s.we_M = 1; s.rd_M = 7; s.rs2 = 7; s.u2 = 1; apply(s);
        apply(idle());

        // Long op: RAW and WAW wait, advance on the long_done cycle
        s = idle(); s.long_E = 1; s.mdu_ready = 1; s.rd_E = 9; apply(s);
        repeat (3) begin s = idle(); s.rs1 = 9; s.u1 = 1; apply(s); end
        s = idle(); s.rd_D = 9; apply(s);
        s = idle(); s.rs1 = 9; s.u1 = 1; s.long_done = 1; s.long_rd = 9; apply(s);
        apply(idle());

        // Priority: busy beats branch and load-use; without busy the branch wins
        s = idle(); s.busy = 1; s.je = 1; s.we_E = 1; s.load_E = 1; s.rd_E = 7; s.rs1 = 7; s.u1 = 1;
        apply(s);
        s.busy = 0; apply(s);
        apply(idle());

        // MDU not ready: held, no scoreboard bit until the launch goes through
        s = idle(); s.long_E = 1; s.rd_E = 12; apply(s); apply(s);
        s.mdu_ready = 1; apply(s);
        s = idle(); s.rs1 = 12; s.u1 = 1; apply(s);
        s.long_done = 1; s.long_rd = 12; apply(s);

        // Completion during an LSU freeze still clears its bit
        s = idle(); s.long_E = 1; s.mdu_ready = 1; s.rd_E = 13; apply(s);
        s = idle(); s.busy = 1; s.long_done = 1; s.long_rd = 13; apply(s);
        s = idle(); s.rs2 = 13; s.u2 = 1; apply(s);

        // x0 never matches and is never marked
        s = idle(); s.we_E = 1; s.load_E = 1; s.rd_E = 0; s.rs1 = 0; s.u1 = 1;
        s.we_M = 1; s.rd_M = 0; s.rs2 = 0; s.u2 = 1; apply(s);
        s = idle(); s.long_E = 1; s.mdu_ready = 1; s.rd_E = 0; apply(s);
        s = idle(); s.rs1 = 0; s.u1 = 1; apply(s);

        // Reset with three outstanding long ops and a live forwarding select
        foreach (s.rs1[i]) begin end
        s = idle(); s.long_E = 1; s.mdu_ready = 1; s.rd_E = 3; apply(s);
        s.rd_E = 4; apply(s);
        s.rd_E = 6; apply(s);
        s = idle(); s.we_E = 1; s.rd_E = 2; s.rs1 = 2; s.u1 = 1; apply(s);
        s = idle(); s.rst = 1; apply(s);
        s = idle(); s.rs1 = 3; s.u1 = 1; s.rd_D = 4; apply(s);
        s = idle(); s.long_done = 1; s.long_rd = 4; s.rs2 = 6; s.u2 = 1; apply(s);
        apply(idle());

        // Randomised traffic over a small register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst       = ($urandom_range(0, 199) == 0);
            s.je        = ($urandom_range(0, 7) == 0);
            s.busy      = ($urandom_range(0, 7) == 0);
            s.rs1       = 5'($urandom_range(0, 7));
            s.rs2       = 5'($urandom_range(0, 7));
            s.u1        = ($urandom_range(0, 3) != 0);
            s.u2        = ($urandom_range(0, 1) == 0);
            s.rd_D      = 5'($urandom_range(0, 7));
            s.rd_E      = 5'($urandom_range(0, 7));
            s.rd_M      = 5'($urandom_range(0, 7));
            s.long_E    = ($urandom_range(0, 5) == 0);
            s.we_E      = !s.long_E && ($urandom_range(0, 1) == 0);
            s.load_E    = s.we_E && ($urandom_range(0, 3) == 0);
            s.we_M      = ($urandom_range(0, 1) == 0);
            s.mdu_ready = ($urandom_range(0, 3) != 0);
            s.long_done = ($urandom_range(0, 3) == 0);
            s.long_rd   = 5'($urandom_range(0, 7));
            apply(s);
        end
        apply(idle());
        apply(idle());

        // Let the monitor drain, bounded
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 10)) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
